// File: rtl/uncache_ctrl.sv
// Uncached access sequencer: stalls the memory stage and runs one single-beat read or write
// over the bridge req/ack interface. Define UNCACHE_POSTED_WRITE_EN for posted writes.
module uncache_ctrl #(
  parameter int unsigned MAX_OUTSTANDING = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        sram_en,
  input  logic [3:0]  sram_wen,
  input  logic [31:0] sram_addr,
  input  logic [31:0] sram_wdata,
  input  logic        cached,
  output logic        stallreq,
  output logic        hit,
  output logic        refresh,
  output logic        rd_req,
  output logic [31:0] rd_addr,
  input  logic        rd_ack,
  input  logic        rdata_valid,
  output logic        wr_req,
  output logic [31:0] wr_addr,
  output logic [31:0] wr_data,
  output logic [3:0]  wr_strb,
  input  logic        wr_ack,
  input  logic        wr_done
);

  localparam int unsigned AW = 32;
  localparam int unsigned DW = 32;
  localparam int unsigned SW = 4;

  if (MAX_OUTSTANDING == 0) begin : g_bad_cfg
    $error("uncache_ctrl: MAX_OUTSTANDING must be at least 1");
  end

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_RD_REQ  = 3'd1,
    S_RD_WAIT = 3'd2,
    S_WR_REQ  = 3'd3,
    S_WR_WAIT = 3'd4,
    S_DONE    = 3'd5
  } state_e;

  state_e        state_q, state_d;
  logic [AW-1:0] addr_q, addr_d;
  logic [DW-1:0] wdata_q, wdata_d;
  logic [SW-1:0] wen_q, wen_d;

  logic          rd_req_q, rd_req_d;
  logic [AW-1:0] rd_addr_q, rd_addr_d;
  logic          wr_req_q, wr_req_d;
  logic [AW-1:0] wr_addr_q, wr_addr_d;
  logic [DW-1:0] wr_data_q, wr_data_d;
  logic [SW-1:0] wr_strb_q, wr_strb_d;
  logic          hit_q, hit_d;

  logic          rd_acc, wr_acc;
  logic          blk_rd_d, blk_wr_d;

  // An ack only counts while the matching request is actually on the wire.
  assign rd_acc = (state_q == S_RD_REQ) && rd_req_q && rd_ack;
  assign wr_acc = (state_q == S_WR_REQ) && wr_req_q && wr_ack;

`ifdef UNCACHE_POSTED_WRITE_EN
  localparam int unsigned CNT_W = $clog2(MAX_OUTSTANDING + 1);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  // Writes in flight: ack adds one, response removes one, a stray response at zero is dropped.
  always_comb begin
    cnt_d = cnt_q;
    if (wr_acc && !wr_done) begin
      cnt_d = cnt_q + CNT_W'(1);
    end else if (!wr_acc && wr_done && (cnt_q != '0)) begin
      cnt_d = cnt_q - CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign blk_rd_d = (cnt_d != '0);
  assign blk_wr_d = (cnt_d == CNT_W'(MAX_OUTSTANDING));
`else
  assign blk_rd_d = 1'b0;
  assign blk_wr_d = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next state and request capture.
  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    wen_d   = wen_q;
    case (state_q)
      S_IDLE: begin
        if (sram_en && !cached) begin
          addr_d  = sram_addr;
          wdata_d = sram_wdata;
          wen_d   = sram_wen;
          state_d = (sram_wen != '0) ? S_WR_REQ : S_RD_REQ;
        end
      end
      S_RD_REQ: begin
        if (rd_acc) begin
          state_d = rdata_valid ? S_DONE : S_RD_WAIT;
        end
      end
      S_RD_WAIT: begin
        if (rdata_valid) begin
          state_d = S_DONE;
        end
      end
      S_WR_REQ: begin
        if (wr_acc) begin
`ifdef UNCACHE_POSTED_WRITE_EN
          state_d = S_DONE;
`else
          state_d = wr_done ? S_DONE : S_WR_WAIT;
`endif
        end
      end
      S_WR_WAIT: begin
`ifdef UNCACHE_POSTED_WRITE_EN
        state_d = S_IDLE;
`else
        if (wr_done) begin
          state_d = S_DONE;
        end
`endif
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Outputs: bridge requests are registered from the next state, stall and refresh are combinational.
  always_comb begin
    stallreq  = 1'b0;
    refresh   = 1'b0;
    rd_req_d  = 1'b0;
    rd_addr_d = '0;
    wr_req_d  = 1'b0;
    wr_addr_d = '0;
    wr_data_d = '0;
    wr_strb_d = '0;
    hit_d     = 1'b0;

    case (state_q)
      S_IDLE:                                    stallreq = sram_en && !cached;
      S_RD_REQ, S_RD_WAIT, S_WR_REQ, S_WR_WAIT:  stallreq = 1'b1;
      default:                                   stallreq = 1'b0;
    endcase

    refresh = rdata_valid && (rd_acc || (state_q == S_RD_WAIT));

    if ((state_d == S_RD_REQ) && !blk_rd_d) begin
      rd_req_d  = 1'b1;
      rd_addr_d = addr_d;
    end
    if ((state_d == S_WR_REQ) && !blk_wr_d) begin
      wr_req_d  = 1'b1;
      wr_addr_d = addr_d;
      wr_data_d = wdata_d;
      wr_strb_d = wen_d;
    end
    hit_d = (state_d == S_DONE) && (wen_d == '0);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      addr_q    <= '0;
      wdata_q   <= '0;
      wen_q     <= '0;
      rd_req_q  <= 1'b0;
      rd_addr_q <= '0;
      wr_req_q  <= 1'b0;
      wr_addr_q <= '0;
      wr_data_q <= '0;
      wr_strb_q <= '0;
      hit_q     <= 1'b0;
    end else begin
      addr_q    <= addr_d;
      wdata_q   <= wdata_d;
      wen_q     <= wen_d;
      rd_req_q  <= rd_req_d;
      rd_addr_q <= rd_addr_d;
      wr_req_q  <= wr_req_d;
      wr_addr_q <= wr_addr_d;
      wr_data_q <= wr_data_d;
      wr_strb_q <= wr_strb_d;
      hit_q     <= hit_d;
    end
  end

  assign rd_req  = rd_req_q;
  assign rd_addr = rd_addr_q;
  assign wr_req  = wr_req_q;
  assign wr_addr = wr_addr_q;
  assign wr_data = wr_data_q;
  assign wr_strb = wr_strb_q;
  assign hit     = hit_q;

endmodule

// File: tb/tb_uncache_ctrl.sv
// Bench for uncache_ctrl: transaction timelines give the expected waveform of every output each cycle.
`timescale 1ns/1ps
module tb_uncache_ctrl;

  localparam int unsigned MAXO = 2;

  logic        clk = 1'b0;
  logic        rst;
  logic        sram_en, cached, rd_ack, rdata_valid, wr_ack, wr_done;
  logic [3:0]  sram_wen;
  logic [31:0] sram_addr, sram_wdata;
  logic        stallreq, hit, refresh, rd_req, wr_req;
  logic [31:0] rd_addr, wr_addr, wr_data;
  logic [3:0]  wr_strb;

  uncache_ctrl #(.MAX_OUTSTANDING(MAXO)) dut (
    .clk(clk), .rst(rst),
    .sram_en(sram_en), .sram_wen(sram_wen), .sram_addr(sram_addr), .sram_wdata(sram_wdata),
    .cached(cached), .stallreq(stallreq), .hit(hit), .refresh(refresh),
    .rd_req(rd_req), .rd_addr(rd_addr), .rd_ack(rd_ack), .rdata_valid(rdata_valid),
    .wr_req(wr_req), .wr_addr(wr_addr), .wr_data(wr_data), .wr_strb(wr_strb),
    .wr_ack(wr_ack), .wr_done(wr_done)
  );

  always #5 clk = ~clk;

  int n_pass  = 0;
  int n_total = 0;

  logic        e_stall, e_hit, e_refresh, e_rd_req, e_wr_req;
  logic [31:0] e_rd_addr, e_wr_addr, e_wr_data;
  logic [3:0]  e_wr_strb;
  bit          chk_en = 1'b0;

  int   obs_stall, obs_refresh, obs_hit, obs_rd_txn, obs_wr_txn;
  logic prev_rd_req = 1'b0;
  logic prev_wr_req = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
  endtask

  task automatic idle_inputs();
    sram_en = 1'b0; sram_wen = 4'h0; sram_addr = '0; sram_wdata = '0; cached = 1'b0;
    rd_ack = 1'b0; rdata_valid = 1'b0; wr_ack = 1'b0; wr_done = 1'b0;
  endtask

  task automatic exp_quiet();
    e_stall = 1'b0; e_hit = 1'b0; e_refresh = 1'b0; e_rd_req = 1'b0; e_wr_req = 1'b0;
    e_rd_addr = '0; e_wr_addr = '0; e_wr_data = '0; e_wr_strb = '0;
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_stallreq"}, 32'(stallreq), 32'd0);
    check({tag, "_hit"},      32'(hit),      32'd0);
    check({tag, "_refresh"},  32'(refresh),  32'd0);
    check({tag, "_rd_req"},   32'(rd_req),   32'd0);
    check({tag, "_rd_addr"},  rd_addr,       32'd0);
    check({tag, "_wr_req"},   32'(wr_req),   32'd0);
    check({tag, "_wr_addr"},  wr_addr,       32'd0);
    check({tag, "_wr_data"},  wr_data,       32'd0);
    check({tag, "_wr_strb"},  32'(wr_strb),  32'd0);
  endtask

  // Compare process: mid-cycle, after inputs have settled and well away from the rising edge.
  always begin
    @(negedge clk);
    #2;
    if (chk_en) begin
      check("stallreq", 32'(stallreq), 32'(e_stall));
      check("hit",      32'(hit),      32'(e_hit));
      check("refresh",  32'(refresh),  32'(e_refresh));
      check("rd_req",   32'(rd_req),   32'(e_rd_req));
      check("rd_addr",  rd_addr,       e_rd_addr);
      check("wr_req",   32'(wr_req),   32'(e_wr_req));
      check("wr_addr",  wr_addr,       e_wr_addr);
      check("wr_data",  wr_data,       e_wr_data);
      check("wr_strb",  32'(wr_strb),  32'(e_wr_strb));
    end
    if (stallreq === 1'b1) obs_stall++;
    if (refresh === 1'b1)  obs_refresh++;
    if (hit === 1'b1)      obs_hit++;
    if (rd_req === 1'b1 && prev_rd_req !== 1'b1) obs_rd_txn++;
    if (wr_req === 1'b1 && prev_wr_req !== 1'b1) obs_wr_txn++;
    prev_rd_req = rd_req;
    prev_wr_req = wr_req;
  end

  task automatic clear_obs();
    obs_stall = 0; obs_refresh = 0; obs_hit = 0; obs_rd_txn = 0; obs_wr_txn = 0;
  endtask

  // One quiet cycle so the last transaction cycle has been compared and counted.
  task automatic settle();
    @(negedge clk);
    idle_inputs(); exp_quiet();
    #3;
  endtask

  // Read: rd_ack a cycles after rd_req rises, rdata_valid v cycles after the ack.
  task automatic do_read(input logic [31:0] addr, input int a, input int v, input bit hold_en);
    int done_c;
    done_c = 2 + a + v;
    for (int c = 0; c <= done_c; c++) begin
      @(negedge clk);
      idle_inputs(); exp_quiet();
      sram_en     = (c < done_c) || hold_en;
      sram_addr   = (c == 0) ? addr : $urandom();
      sram_wdata  = $urandom();
      sram_wen    = (c == 0) ? 4'h0 : 4'($urandom());
      cached      = (c == 0) ? 1'b0 : 1'($urandom());
      rd_ack      = (c == 1 + a) || ((v > 1) && (c == 2 + a));
      rdata_valid = (c == 1 + a + v) || ((a > 0) && (c == 1));
      wr_ack      = 1'($urandom());
      wr_done     = 1'($urandom());
      e_stall   = (c < done_c);
      e_rd_req  = (c >= 1) && (c <= 1 + a);
      e_rd_addr = e_rd_req ? addr : 32'd0;
      e_refresh = (c == 1 + a + v);
      e_hit     = (c == done_c);
      chk_en    = 1'b1;
    end
  endtask

`ifndef UNCACHE_POSTED_WRITE_EN
  // Write: wr_ack a cycles after wr_req rises, wr_done d cycles after the ack.
  task automatic do_write(input logic [31:0] addr, input logic [31:0] data, input logic [3:0] wen,
                          input int a, input int d);
    int done_c;
    done_c = 2 + a + d;
    for (int c = 0; c <= done_c; c++) begin
      @(negedge clk);
      idle_inputs(); exp_quiet();
      sram_en     = (c < done_c);
      sram_addr   = (c == 0) ? addr : $urandom();
      sram_wdata  = (c == 0) ? data : $urandom();
      sram_wen    = (c == 0) ? wen  : 4'($urandom());
      wr_ack      = (c == 1 + a) || ((d > 1) && (c == 2 + a));
      wr_done     = (c == 1 + a + d) || ((a > 0) && (c == 1));
      rd_ack      = 1'($urandom());
      rdata_valid = 1'($urandom());
      e_stall   = (c < done_c);
      e_wr_req  = (c >= 1) && (c <= 1 + a);
      e_wr_addr = e_wr_req ? addr : 32'd0;
      e_wr_data = e_wr_req ? data : 32'd0;
      e_wr_strb = e_wr_req ? wen  : 4'd0;
      chk_en    = 1'b1;
    end
  endtask
`else
  int outstanding = 0;

  // Posted: the request is withheld until the bridge backlog allows it, then acked at once.
  // done_mask bit c drives wr_done in transaction cycle c.
  task automatic posted_txn(input bit is_wr, input logic [31:0] addr, input logic [31:0] data,
                            input logic [3:0] wen, input logic [7:0] done_mask);
    int  phase;
    int  c;
    bit  allowed;
    phase = 0;
    c = 0;
    while (phase != 3 && c < 40) begin
      @(negedge clk);
      idle_inputs(); exp_quiet();
      wr_done    = (c < 8) ? done_mask[c] : 1'b0;
      sram_en    = (phase != 2);
      sram_addr  = (c == 0) ? addr : $urandom();
      sram_wdata = (c == 0) ? data : $urandom();
      sram_wen   = (c == 0) ? (is_wr ? wen : 4'h0) : 4'($urandom());
      allowed    = 1'b0;
      if (phase == 0) begin
        e_stall = 1'b1;
        phase = 1;
      end else if (phase == 1) begin
        e_stall = 1'b1;
        allowed = is_wr ? (outstanding < int'(MAXO)) : (outstanding == 0);
        if (allowed) begin
          if (is_wr) begin
            e_wr_req = 1'b1; e_wr_addr = addr; e_wr_data = data; e_wr_strb = wen;
            wr_ack = 1'b1;
          end else begin
            e_rd_req = 1'b1; e_rd_addr = addr;
            rd_ack = 1'b1; rdata_valid = 1'b1; e_refresh = 1'b1;
          end
          phase = 2;
        end
      end else begin
        e_hit = !is_wr;
        phase = 3;
      end
      if (is_wr && allowed && !wr_done) outstanding++;
      else if (!(is_wr && allowed) && wr_done && outstanding > 0) outstanding--;
      chk_en = 1'b1;
      c++;
    end
  endtask
`endif

  initial begin
    idle_inputs(); exp_quiet(); clear_obs();
    rst = 1'b1;
    #1 rst = 1'b0;
    #2 check_all_zero("reset");
    repeat (2) @(negedge clk);
    rst = 1'b1;
    chk_en = 1'b1;
    settle(); clear_obs();

    // Uncached read with a slow data beat.
    do_read(32'hBFAF_8000, 0, 3, 1'b0);
    settle();
    check("t1_stall_cycles", 32'(obs_stall), 32'd5);
    check("t1_refresh_pulses", 32'(obs_refresh), 32'd1);
    check("t1_hit_pulses", 32'(obs_hit), 32'd1);
    check("t1_rd_txns", 32'(obs_rd_txn), 32'd1);
    clear_obs();

    // Cached accesses never leave idle.
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      idle_inputs(); exp_quiet();
      sram_en = 1'b1; cached = 1'b1;
      sram_addr = $urandom(); sram_wen = 4'($urandom()); sram_wdata = $urandom();
      rdata_valid = 1'b1; rd_ack = 1'b1;
    end
    settle();
    check("t2_stall_cycles", 32'(obs_stall), 32'd0);
    check("t2_req_txns", 32'(obs_rd_txn + obs_wr_txn), 32'd0);
    clear_obs();

    // Ack and data in the same cycle: minimum three-cycle read.
    do_read(32'h1FC0_0010, 0, 0, 1'b0);
    settle();
    check("t4_stall_cycles", 32'(obs_stall), 32'd2);
    check("t4_refresh_pulses", 32'(obs_refresh), 32'd1);
    clear_obs();

    // Back-to-back reads with sram_en held through the first completion.
    do_read(32'hBFD0_03F8, 1, 1, 1'b1);
    do_read(32'hBFD0_03FC, 0, 2, 1'b0);
    settle();
    check("t5_rd_txns", 32'(obs_rd_txn), 32'd2);
    check("t5_hit_pulses", 32'(obs_hit), 32'd2);
    clear_obs();

`ifndef UNCACHE_POSTED_WRITE_EN
    // Uncached write that waits for its response.
    do_write(32'hBFAF_F000, 32'hDEAD_BEEF, 4'h3, 2, 2);
    settle();
    check("t3_hit_pulses", 32'(obs_hit), 32'd0);
    check("t3_wr_txns", 32'(obs_wr_txn), 32'd1);
    check("t3_stall_cycles", 32'(obs_stall), 32'd6);
    clear_obs();

    do_write(32'hBFAF_F004, 32'hA5A5_0F0F, 4'hC, 0, 0);
    settle();
    check("w_min_stall_cycles", 32'(obs_stall), 32'd2);
    clear_obs();
`else
    // Two posted writes, a third blocked at the limit, then a read held for the backlog.
    posted_txn(1'b1, 32'hBFAF_F000, 32'h1111_1111, 4'hF, 8'h00);
    posted_txn(1'b1, 32'hBFAF_F004, 32'h2222_2222, 4'h3, 8'h00);
    settle();
    check("p_wr_txns", 32'(obs_wr_txn), 32'd2);
    clear_obs();
    posted_txn(1'b1, 32'hBFAF_F008, 32'h3333_3333, 4'hC, 8'h04);
    settle();
    check("p_blocked_wr_stall", 32'(obs_stall), 32'd4);
    clear_obs();
    posted_txn(1'b0, 32'hBFAF_F00C, 32'h0, 4'h0, 8'h14);
    settle();
    check("p_rd_stall", 32'(obs_stall), 32'd6);
    check("p_rd_txns", 32'(obs_rd_txn), 32'd1);
    check("p_hit_pulses", 32'(obs_hit), 32'd1);
    clear_obs();
`endif

    // Reset asserted while waiting for read data.
    chk_en = 1'b0;
    @(negedge clk); idle_inputs(); sram_en = 1'b1; sram_addr = 32'hBFAF_8100;
    @(negedge clk); idle_inputs(); rd_ack = 1'b1;
    @(negedge clk); idle_inputs();
    #2 check("rst_pre_stallreq", 32'(stallreq), 32'd1);
    #1 rst = 1'b0;
    #1 check_all_zero("rst_mid");
    @(negedge clk); rst = 1'b1; exp_quiet(); chk_en = 1'b1;
    settle(); clear_obs();

    do_read(32'hBFAF_8200, 1, 0, 1'b0);
    settle();
    check("post_rst_hit_pulses", 32'(obs_hit), 32'd1);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1);
  end

endmodule

// File: doc/uncache_ctrl.md
# uncache_ctrl

- Control stage directly upstream of the uncached read-data register.
- Accepts the data-side SRAM-style request from the memory pipeline stage and, when the access is uncached, stalls the pipeline.
- Runs exactly one single-beat read or write through the AXI bridge's simple request/ack interface.
- Produces the `refresh` and `hit` strobes the data register uses to capture `axi_rdata` and present it one cycle later.

## Interface

Parameters:
- `MAX_OUTSTANDING`, default 2: maximum posted writes in flight; only used when posted writes are compiled in.

Ports (name, direction, width, meaning):
- `clk`  in  1  clock; all state updates on the rising edge.
- `rst`  in  1  asynchronous active-low reset.
- `sram_en`  in  1  memory-stage access valid.
- `sram_wen`  in  4  byte write enables; nonzero means write.
- `sram_addr`  in  32  physical address.
- `sram_wdata`  in  32  store data.
- `cached`  in  1  address attribute; 1 means cached, and the block ignores the access.
- `stallreq`  out  1  pipeline stall request (combinational).
- `hit`  out  1  one-cycle strobe: an uncached read completed this cycle.
- `refresh`  out  1  capture strobe for `axi_rdata` in the data register.
- `rd_req`  out  1  read request to the bridge.
- `rd_addr`  out  32  read address.
- `rd_ack`  in  1  bridge accepted the read.
- `rdata_valid`  in  1  read data beat present on `axi_rdata`.
- `wr_req`  out  1  write request to the bridge.
- `wr_addr`  out  32  write address.
- `wr_data`  out  32  write data.
- `wr_strb`  out  4  write strobes.
- `wr_ack`  in  1  bridge accepted the write.
- `wr_done`  in  1  write response (B) received.

## Operation

Request capture:
- State register holds one of IDLE, RD_REQ, RD_WAIT, WR_REQ, WR_WAIT, DONE.
- In IDLE, when `sram_en & ~cached`, latch `sram_addr`, `sram_wdata` and `sram_wen`.
- Then go to WR_REQ if `|sram_wen`, otherwise to RD_REQ.
- Cached accesses never leave IDLE.

Read path:
- RD_REQ drives `rd_req=1` with `rd_addr` stable, and holds it until `rd_ack`.
- On `rd_ack` go to RD_WAIT; if `rdata_valid` arrives in the same cycle, go straight to DONE.
- RD_WAIT waits for `rdata_valid`, then goes to DONE.

Write path:
- WR_REQ drives `wr_req=1` with `wr_addr`, `wr_data` and `wr_strb` stable, and holds them until `wr_ack`.
- On `wr_ack` go to WR_WAIT; if `wr_done` arrives in the same cycle, go straight to DONE.
- WR_WAIT waits for `wr_done`, then goes to DONE.

Completion:
- DONE lasts exactly one cycle, then returns to IDLE unconditionally.
- `sram_en` is ignored in DONE, so the request that just completed is never reissued.

Output equations:
- `stallreq` = (IDLE & `sram_en` & ~`cached`) | state ∈ {RD_REQ, RD_WAIT, WR_REQ, WR_WAIT}. It is low in DONE.
- `refresh` = `rdata_valid` & ((RD_REQ & `rd_ack`) | RD_WAIT).
- `hit` = DONE & (the latched request was a read). `hit` is never asserted for writes.
- `rdata_valid`, `rd_ack`, `wr_ack` and `wr_done` are ignored in states where they are not expected.

## Timing

- Reset (async, `rst=0`):
  - state = IDLE.
  - All outputs 0: `stallreq`, `hit`, `refresh`, `rd_req`, `wr_req`, `rd_addr`, `wr_addr`, `wr_data`, `wr_strb`.
  - Outstanding counter = 0.
  - Reset asserted mid-transaction abandons it; the bridge shares the reset.
- Stall timing:
  - `stallreq` rises in the same cycle an uncached `sram_en` is seen.
  - It falls in DONE, so the pipeline advances at the end of DONE.
- Read data path:
  - `axi_rdata` is captured at the edge where `refresh=1`.
  - `hit` in DONE is registered by the data stage, so the data is visible to the next pipeline stage one cycle after DONE.
- Minimum latencies:
  - Read: IDLE → RD_REQ → DONE, with `rd_ack` and `rdata_valid` both arriving in RD_REQ. That is 3 cycles including DONE.
  - Write: the same 3 cycles.
- Request outputs hold their value while waiting for the ack; they drop to 0 the cycle after the ack.

## Configuration

Macro `UNCACHE_POSTED_WRITE_EN`.

Without the macro:
- Each write waits for `wr_done` before DONE, as described above.

With the macro:
- A write goes WR_REQ → DONE on `wr_ack`, and WR_WAIT is unused.
- A counter of width clog2(`MAX_OUTSTANDING`+1) tracks posted writes:
  - +1 on `wr_ack`, -1 on `wr_done`.
  - When both occur in the same cycle, the count is unchanged.
- RD_REQ keeps `rd_req=0` (stalling) until the counter is 0, which preserves read-after-write ordering.
- WR_REQ keeps `wr_req=0` while the counter equals `MAX_OUTSTANDING`.
- A `wr_done` arriving with the counter at 0 is a bridge error; the counter stays at 0 and does not wrap.

## Test plan

1. Uncached read, addr 0xBFAF_8000:
   - Stimulus: `rd_ack` 1 cycle after `rd_req`, `rdata_valid` with 0x1234_5678 3 cycles later.
   - Required: `stallreq` high for 5 cycles, one `refresh` pulse, one `hit` pulse in DONE, `rd_addr`=0xBFAF_8000.
2. Cached access (`cached=1`, `sram_en=1`):
   - Required: `stallreq`=0, no `rd_req`/`wr_req`, state stays IDLE.
3. Uncached write, `sram_wen`=0x3, data 0xDEAD_BEEF:
   - Required: `wr_strb`=0x3 and `wr_data` held until `wr_ack`; DONE only after `wr_done`; `hit` stays 0.
4. Same-cycle `rd_ack` and `rdata_valid` in RD_REQ:
   - Required: `refresh` in that cycle, next state DONE, RD_WAIT skipped.
5. Back-to-back uncached reads with `sram_en` held across DONE:
   - Required: exactly two `rd_req` transactions, and DONE does not re-trigger.
6. Posted writes (`UNCACHE_POSTED_WRITE_EN`, `MAX_OUTSTANDING`=2):
   - Stimulus: two writes acked with no `wr_done`, then a read.
   - Required: `rd_req` stays 0 until both `wr_done` arrive. A third write is blocked at count 2.
   - Also: `rst` pulsed low mid-RD_WAIT returns all outputs to 0 asynchronously.
